// File: rtl/alu_seq_legv8_pkg.sv
// Shared opcodes, FSM states and flag-bit layout for alu_seq_legv8.
// Status/flag vectors are ordered {V,C,N,Z}.
package alu_seq_legv8_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    localparam int FLG_V = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [3:0] mk_status(input logic v, input logic c,
                                             input logic n, input logic z);
        logic [3:0] s;
        s        = 4'b0000;
        s[FLG_V] = v;
        s[FLG_C] = c;
        s[FLG_N] = n;
        s[FLG_Z] = z;
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_legv8_if.sv
// Operand/result handshake bundle between a requester (master) and the ALU (slave).
interface alu_seq_legv8_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C0;
    logic [4:0]   FS;
    logic         set_flags;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] F;
    logic [3:0]   res_status;
    logic [3:0]   flags;
    logic         busy;

    modport master (
        output in_valid, A, B, C0, FS, set_flags, out_ready,
        input  in_ready, out_valid, F, res_status, flags, busy
    );

    modport slave (
        input  in_valid, A, B, C0, FS, set_flags, out_ready,
        output in_ready, out_valid, F, res_status, flags, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low N product bits.
// Only compiled when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
    parameter int N  = 64,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_product
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    // Shift-add datapath and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= {N{1'b0}};
            r_mplier <= {N{1'b0}};
            r_acc    <= {N{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= {N{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end else begin
                r_acc <= r_acc;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= {CW{1'b0}};
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    // done flags the final iteration so the product is complete on the following cycle
    assign o_done    = r_busy & (r_cnt == LAST);
    assign o_product = r_acc;

endmodule
`endif

// File: rtl/alu_seq_legv8.sv
// Handshaked LEGv8-style ALU with registered result, status and held flag register.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise op 110 returns zero.
module alu_seq_legv8
    import alu_seq_legv8_pkg::*;
#(
    parameter int N   = 64,
    parameter int SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_legv8_if.slave io_bus
);

    logic [2:0]     w_op;
    logic [N-1:0]   w_a_s;
    logic [N-1:0]   w_b_s;
    logic [N:0]     w_sum;
    logic [SHW-1:0] w_shamt;
    logic [N-1:0]   w_alu_f;
    logic           w_alu_c;
    logic           w_alu_v;
    logic [3:0]     w_alu_status;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_is_mul;

    state_e         r_state;
    logic [N-1:0]   r_f;
    logic [3:0]     r_status;
    logic [3:0]     r_flags;
    logic           r_out_valid;

    assign w_op    = io_bus.FS[4:2];
    assign w_a_s   = io_bus.FS[0] ? ~io_bus.A : io_bus.A;
    assign w_b_s   = io_bus.FS[1] ? ~io_bus.B : io_bus.B;
    assign w_sum   = {1'b0, w_a_s} + {1'b0, w_b_s} + {{N{1'b0}}, io_bus.C0};
    assign w_shamt = io_bus.B[SHW-1:0];

    // Single-cycle result for every op except an enabled multiply
    always_comb begin
        w_alu_f = {N{1'b0}};
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (w_op)
            OP_AND: w_alu_f = w_a_s & w_b_s;
            OP_OR:  w_alu_f = w_a_s | w_b_s;
            OP_ADD: begin
                w_alu_f = w_sum[N-1:0];
                w_alu_c = w_sum[N];
                w_alu_v = (w_a_s[N-1] == w_b_s[N-1]) & (w_sum[N-1] != w_a_s[N-1]);
            end
            OP_XOR: w_alu_f = w_a_s ^ w_b_s;
            OP_LSL: w_alu_f = io_bus.A << w_shamt;
            OP_LSR: w_alu_f = io_bus.A >> w_shamt;
            OP_ASR: w_alu_f = $signed(io_bus.A) >>> w_shamt;
            OP_MUL: w_alu_f = {N{1'b0}};
            default: w_alu_f = {N{1'b0}};
        endcase
    end

    assign w_alu_status = mk_status(w_alu_v, w_alu_c, w_alu_f[N-1], ~|w_alu_f);
    assign w_in_ready   = (r_state == ST_IDLE) & (~r_out_valid | io_bus.out_ready);
    assign w_accept     = io_bus.in_valid & w_in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic           w_mul_done;
    logic [N-1:0]   w_mul_p;
    logic [3:0]     w_mul_status;
    logic           r_mul_setf;

    assign w_is_mul     = (w_op == OP_MUL);
    assign w_mul_status = mk_status(1'b0, 1'b0, w_mul_p[N-1], ~|w_mul_p);

    alu_mul_iter #(
        .N (N)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept & w_is_mul),
        .i_a       (io_bus.A),
        .i_b       (io_bus.B),
        .o_done    (w_mul_done),
        .o_product (w_mul_p)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    // Control FSM together with the output and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_f         <= {N{1'b0}};
            r_status    <= 4'b0000;
            r_flags     <= 4'b0000;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mul_setf  <= 1'b0;
`endif
        end else begin
            // A drain clears out_valid unless a load below supersedes it
            if (io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_is_mul) begin
                        r_f         <= w_alu_f;
                        r_status    <= w_alu_status;
                        r_out_valid <= 1'b1;
                        if (io_bus.set_flags) begin
                            r_flags <= w_alu_status;
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (w_accept) begin
                        r_state    <= ST_MUL;
                        r_mul_setf <= io_bus.set_flags;
                    end
`endif
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid || io_bus.out_ready) begin
                        r_f         <= w_mul_p;
                        r_status    <= w_mul_status;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                        if (r_mul_setf) begin
                            r_flags <= w_mul_status;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.F          = r_f;
    assign io_bus.res_status = r_status;
    assign io_bus.flags      = r_flags;
`ifdef ALU_SEQ_MUL_EN
    assign io_bus.busy       = (r_state != ST_IDLE);
`else
    assign io_bus.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_legv8.sv
// Directed self-checking bench: a 64-bit and an 8-bit alu_seq_legv8 sharing clock and reset.
module tb_alu_seq_legv8;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_legv8_if #(.N(64)) bus64 ();
    alu_seq_legv8_if #(.N(8))  bus8  ();

    alu_seq_legv8 #(.N(64)) u_dut64 (.clk(clk), .rst(rst), .io_bus(bus64));
    alu_seq_legv8 #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .io_bus(bus8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic c0,
                        input logic [4:0] fs, input logic sf);
        bus64.A = a; bus64.B = b; bus64.C0 = c0; bus64.FS = fs; bus64.set_flags = sf;
        bus64.in_valid = 1'b1;
        #1;
        chk("rdy64", {63'd0, bus64.in_ready}, 64'd1);
        tick();
        bus64.in_valid = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c0,
                       input logic [4:0] fs, input logic sf);
        bus8.A = a; bus8.B = b; bus8.C0 = c0; bus8.FS = fs; bus8.set_flags = sf;
        bus8.in_valid = 1'b1;
        #1;
        chk("rdy8", {63'd0, bus8.in_ready}, 64'd1);
        tick();
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus64.in_valid = 1'b0; bus64.A = 64'd0; bus64.B = 64'd0; bus64.C0 = 1'b0;
        bus64.FS = 5'b00000; bus64.set_flags = 1'b0; bus64.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = 8'd0; bus8.B = 8'd0; bus8.C0 = 1'b0;
        bus8.FS = 5'b00000; bus8.set_flags = 1'b0; bus8.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_f64",     bus64.F, 64'd0);
        chk("rst_st64",    {60'd0, bus64.res_status}, 64'd0);
        chk("rst_flags64", {60'd0, bus64.flags}, 64'd0);
        chk("rst_ov64",    {63'd0, bus64.out_valid}, 64'd0);
        chk("rst_busy8",   {63'd0, bus8.busy}, 64'd0);
        rst = 1'b0;
        tick();

        // Signed overflow on ADD, flags captured
        op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'b01000, 1'b1);
        chk("add_ov_f",  bus64.F, 64'h8000_0000_0000_0000);
        chk("add_ov_st", {60'd0, bus64.res_status}, 64'hA);
        chk("add_ov_fl", {60'd0, bus64.flags}, 64'hA);
        chk("add_ov_v",  {63'd0, bus64.out_valid}, 64'd1);

        // SUB via inverted B and carry-in, flags untouched
        op64(64'd5, 64'd5, 1'b1, 5'b01010, 1'b0);
        chk("sub_f",  bus64.F, 64'd0);
        chk("sub_st", {60'd0, bus64.res_status}, 64'h5);
        chk("sub_fl", {60'd0, bus64.flags}, 64'hA);

        op64(64'h8000_0000_0000_0000, 64'd63, 1'b0, 5'b11100, 1'b1);
        chk("asr_f",  bus64.F, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("asr_st", {60'd0, bus64.res_status}, 64'h2);
        chk("asr_fl", {60'd0, bus64.flags}, 64'h2);

        op64(64'h8000_0000_0000_0000, 64'd63, 1'b0, 5'b10100, 1'b0);
        chk("lsr_f",  bus64.F, 64'd1);
        chk("lsr_st", {60'd0, bus64.res_status}, 64'h0);

        // Shift amount ignores B bits above the low 6
        op64(64'd3, 64'd68, 1'b0, 5'b10000, 1'b0);
        chk("lsl_f", bus64.F, 64'h30);

        op64(64'd0, 64'hFF, 1'b0, 5'b01101, 1'b0);
        chk("xor_f",  bus64.F, 64'hFFFF_FFFF_FFFF_FF00);
        chk("xor_st", {60'd0, bus64.res_status}, 64'h2);

        op64(64'd0, 64'd0, 1'b0, 5'b00100, 1'b1);
        chk("or_st", {60'd0, bus64.res_status}, 64'h1);
        chk("or_fl", {60'd0, bus64.flags}, 64'h1);

        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 5'b01000, 1'b1);
        chk("addc_f",  bus64.F, 64'd0);
        chk("addc_st", {60'd0, bus64.res_status}, 64'h5);
        chk("addc_fl", {60'd0, bus64.flags}, 64'h5);

        tick();
        chk("drain_ov", {63'd0, bus64.out_valid}, 64'd0);

        // Backpressure: result held, nothing accepted, then drain and accept together
        bus64.out_ready = 1'b0;
        op64(64'd2, 64'd3, 1'b0, 5'b01000, 1'b1);
        chk("bp_f0",  bus64.F, 64'd5);
        chk("bp_fl0", {60'd0, bus64.flags}, 64'h0);
        bus64.A = 64'hF0; bus64.B = 64'h3C; bus64.C0 = 1'b0; bus64.FS = 5'b00000;
        bus64.set_flags = 1'b0; bus64.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_f",   bus64.F, 64'd5);
            chk("bp_ov",  {63'd0, bus64.out_valid}, 64'd1);
            chk("bp_rdy", {63'd0, bus64.in_ready}, 64'd0);
            chk("bp_fl",  {60'd0, bus64.flags}, 64'h0);
        end
        bus64.out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", {63'd0, bus64.in_ready}, 64'd1);
        tick();
        bus64.in_valid = 1'b0;
        chk("bp_and_f",  bus64.F, 64'h30);
        chk("bp_and_ov", {63'd0, bus64.out_valid}, 64'd1);
        chk("bp_and_fl", {60'd0, bus64.flags}, 64'h0);

        op8(8'h7F, 8'h01, 1'b0, 5'b01000, 1'b0);
        chk("add8_f",  {56'd0, bus8.F}, 64'h80);
        chk("add8_st", {60'd0, bus8.res_status}, 64'hA);

        op8(8'd13, 8'd11, 1'b0, 5'b11000, 1'b1);
`ifdef ALU_SEQ_MUL_EN
        for (int i = 0; i < 8; i++) begin
            chk("mul_ov",   {63'd0, bus8.out_valid}, 64'd0);
            chk("mul_rdy",  {63'd0, bus8.in_ready}, 64'd0);
            chk("mul_busy", {63'd0, bus8.busy}, 64'd1);
            tick();
        end
        chk("mul_ov8", {63'd0, bus8.out_valid}, 64'd0);
        tick();
        chk("mul_ov9", {63'd0, bus8.out_valid}, 64'd1);
        chk("mul_f",   {56'd0, bus8.F}, 64'h8F);
        chk("mul_st",  {60'd0, bus8.res_status}, 64'h2);
        chk("mul_fl",  {60'd0, bus8.flags}, 64'h2);
        chk("mul_bz",  {63'd0, bus8.busy}, 64'd0);
`else
        chk("mul_ov", {63'd0, bus8.out_valid}, 64'd1);
        chk("mul_f",  {56'd0, bus8.F}, 64'h0);
        chk("mul_st", {60'd0, bus8.res_status}, 64'h1);
        chk("mul_fl", {60'd0, bus8.flags}, 64'h1);
        chk("mul_bz", {63'd0, bus8.busy}, 64'd0);
`endif

        // Reset in the middle of an operation
        op8(8'd3, 8'd5, 1'b0, 5'b11000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy", {63'd0, bus8.busy}, 64'd0);
        chk("mrst_ov",   {63'd0, bus8.out_valid}, 64'd0);
        chk("mrst_f",    {56'd0, bus8.F}, 64'd0);
        chk("mrst_st",   {60'd0, bus8.res_status}, 64'd0);
        chk("mrst_fl",   {60'd0, bus8.flags}, 64'd0);
        chk("mrst_f64",  bus64.F, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        op8(8'hF0, 8'h3C, 1'b0, 5'b00000, 1'b0);
        chk("post_and_f",  {56'd0, bus8.F}, 64'h30);
        chk("post_and_st", {60'd0, bus8.res_status}, 64'h0);
        chk("post_and_ov", {63'd0, bus8.out_valid}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_legv8.md
ALU_SEQ_LEGV8 -- requirements
Module: alu_seq_legv8

Interface
REQ-001 Parameter N, default 64, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(N), shift-amount width taken from B[SHW-1:0].
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode bundle is valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 A, B  input  N each  operands.
REQ-008 C0  input  1  adder carry-in.
REQ-009 FS  input  5  FS[0] invert A, FS[1] invert B, FS[4:2] op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR, 110 MUL, 111 ASR.
REQ-010 set_flags  input  1  update the flag register with this result.
REQ-011 out_valid  output  1  F/res_status hold a result.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 F  output  N  result.
REQ-014 res_status  output  4  {V,C,N,Z} of the current result.
REQ-015 flags  output  4  {V,C,N,Z} held flag register.
REQ-016 busy  output  1  multiply in progress.

Function
REQ-017 A_s = FS[0] ? ~A : A; B_s = FS[1] ? ~B : B; logic and ADD ops use A_s, B_s.
REQ-018 LSL/LSR/ASR use raw A and B[SHW-1:0]; ASR replicates A[N-1].
REQ-019 ADD: {C,F} = A_s + B_s + C0, N+1 bits; V = (A_s[N-1]==B_s[N-1]) & (F[N-1]!=A_s[N-1]).
REQ-020 Non-ADD ops: C=0, V=0; all ops: N=F[N-1], Z=(F==0).
REQ-021 MUL: F = low N bits of unsigned A*B (raw operands), iterative shift-add, one bit per cycle.
REQ-022 in_ready = (state==IDLE) & (~out_valid | out_ready); transfer in on in_valid & in_ready.
REQ-023 Non-MUL ops: result registered, out_valid asserted the cycle after acceptance (latency 1); throughput 1/cycle while out_ready high.
REQ-024 States IDLE, MUL, DONE; IDLE->MUL on accepted MUL; MUL counts N cycles then ->DONE; DONE loads output register when it is empty or being drained, then ->IDLE.
REQ-025 MUL latency N+1 cycles acceptance to out_valid; busy high in MUL and DONE.
REQ-026 F, res_status, out_valid stable while out_valid & ~out_ready.
REQ-027 flags <= res_status on the cycle a result with captured set_flags=1 is loaded into the output register; unchanged otherwise.
REQ-028 Output-register load and out_ready drain in the same cycle: new result wins, out_valid stays high.

Reset
REQ-029 reset asserted at any time (incl. mid-MUL): state=IDLE, out_valid=0, F=0, res_status=0, flags=0, busy=0, counter=0; in-flight operation discarded.
REQ-030 in_ready may rise the first clock edge after reset deasserts.

Configuration
REQ-031 ALU_SEQ_MUL_EN defined: MUL implemented per REQ-021/024/025.
REQ-032 ALU_SEQ_MUL_EN undefined: no multiplier/counter logic; op 110 completes in 1 cycle with F=0, C=V=0, Z=1; busy tied 0.

Structure
REQ-033 Package alu_seq_legv8_pkg: opcode constants (OP_AND..OP_ASR), state enum, flag bit indices.
REQ-034 One sub-module alu_mul_iter (start, operands, done, product) instantiated only under ALU_SEQ_MUL_EN.

Verification
REQ-035 N=64, ADD A=7FFF_FFFF_FFFF_FFFF, B=1, C0=0, set_flags=1 -> F=8000_0000_0000_0000, res_status=1010 (V,N), flags=1010 one cycle later.
REQ-036 SUB: FS=01010, A=5, B=5, C0=1 -> F=0, res_status=0101 (C,Z).
REQ-037 ASR A=8000_0000_0000_0000, B=63 -> F=FFFF_FFFF_FFFF_FFFF; LSR same -> F=1.
REQ-038 N=8, MUL A=13, B=11 -> F=8F, out_valid exactly 9 cycles after acceptance, in_ready low meanwhile.
REQ-039 out_ready held low 5 cycles with ADD result pending -> F stable, in_ready low, no flag change; release -> drains, next op accepted same cycle.
REQ-040 reset pulsed mid-MUL (cycle 3) -> all outputs 0, IDLE; following AND A=F0, B=3C -> F=30.
